// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execution-stage ALU. It accepts a 3-bit ALU control code and two 32-bit
// operands through a valid/ready handshake, and returns a registered result
// through a second valid/ready handshake. Every code completes in one cycle
// except MUL. By default MUL is an iterative shift-add sequence that takes
// 32 cycles and stalls the input side while it runs.
//
// Control codes:
//   AND=000  XOR=001  SLL=010  ADD=011  SUB=100  MUL=101  ADDI=110  SRAI=111
//
// Build option:
//   ALU_EXEC_FAST_MUL_EN - when defined, MUL is computed combinationally and
//                          completes in one cycle like the other codes. The
//                          iterative sequencer and its registers are not built.
//                          Results are bit-identical in both builds.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   synchronous active-high reset
//   in_valid_i   in   1   request valid
//   in_ready_o   out  1   request can be accepted this cycle (combinational)
//   ctrl_i       in   3   ALU control code
//   src1_i       in   32  operand 1
//   src2_i       in   32  operand 2 (register value or sign-extended immediate)
//   out_valid_o  out  1   result_o / zero_o hold a valid result
//   out_ready_i  in   1   downstream accepts the result
//   result_o     out  32  registered result
//   zero_o       out  1   registered (result == 0)
// -----------------------------------------------------------------------------
module alu_exec_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  // Single-cycle datapath. Shift amounts use only b[4:0]; the upper operand
  // bits are ignored for shifts.
  function automatic logic [31:0] alu_single(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [31:0] a_s;
    logic        [4:0]  sh;
    logic        [31:0] r;
    a_s = a;
    sh  = b[4:0];
    r   = 32'h0;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_ADD:  r = a + b;
      OP_ADDI: r = a + b;
      OP_SUB:  r = a - b;
      OP_SRAI: r = a_s >>> sh;
`ifdef ALU_EXEC_FAST_MUL_EN
      // Low 32 bits of the product are the same for signed and unsigned.
      OP_MUL:  r = a * b;
`else
      OP_MUL:  r = 32'h0;
`endif
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Output slot registers
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;

  // Write port into the output slot, driven by the control section below.
  logic        wr_en;
  logic [31:0] wr_data;
  logic        accept;

  assign accept = in_valid_i && in_ready_o;

`ifdef ALU_EXEC_FAST_MUL_EN

  // Every code is single-cycle: no sequencer state at all.
  assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i);

  always_comb begin
    wr_en   = accept;
    wr_data = alu_single(ctrl_i, src1_i, src2_i);
  end

`else

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_next;

  assign in_ready_o = !rst_i && (state_q == S_IDLE) && (!out_valid_q || out_ready_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    wr_en    = 1'b0;
    wr_data  = alu_single(ctrl_i, src1_i, src2_i);
    acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ctrl_i == OP_MUL) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = 32'h0;
            cnt_d    = 5'd0;
            state_d  = S_MUL;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      S_MUL: begin
        // One partial product per cycle; bits shifted past bit 31 of mcand
        // only affect the discarded upper half of the product.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          wr_en   = 1'b1;
          wr_data = acc_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier datapath: only meaningful while in S_MUL, so not reset.
  always_ff @(posedge clk_i) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

`endif

  // Output slot: a new result wins over a drain on the same edge; otherwise
  // the slot empties when downstream takes it and holds while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    if (wr_en) begin
      out_valid_d = 1'b1;
      result_d    = wr_data;
      zero_d      = (wr_data == 32'h0);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;

endmodule
